score_display_scan: RTL and testbench
=====================================

# score_display_scan

Time-multiplexed three-digit seven-segment driver for the score board. Consumes the three BCD digits produced by the score counter (ones, tens, hundreds) and drives one shared segment bus plus three digit-enable lines. Inputs are snapshotted once per scan frame so a digit never tears mid-frame. Illegal BCD codes are flagged with a sticky error bit.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range DIV >= 2.
- ACTIVE_LOW, 1: output polarity. 1 means `an` and `seg` are driven low to light; 0 means high to light.

- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- en  in  1  display enable; low blanks all digits
- num1  in  4  ones digit, BCD
- num2  in  4  tens digit, BCD
- num3  in  4  hundreds digit, BCD
- seg  out  7  segments, bit order {g,f,e,d,c,b,a}
- an  out  3  digit enables, one-hot: an[0] ones, an[1] tens, an[2] hundreds
- err  out  1  sticky illegal-BCD flag

## Operation
- All descriptions below are in active-high logical terms. Physical `an` and `seg` equal the logical value XORed with {ACTIVE_LOW}, replicated to the output width.
- **Prescaler**
  - Counts 0..DIV-1 and wraps.
  - `tick` is asserted on the cycle where the count equals DIV-1.
  - The prescaler is held at 0 while `en` is low.
- **State machine:** states BLANK, DIG0, DIG1, DIG2.
  - On `tick`: BLANK->DIG0, DIG0->DIG1, DIG1->DIG2, DIG2->DIG0.
  - `rst` or `en`=0 forces BLANK on the next edge, from any state.
- **Snapshot**
  - On every transition into DIG0, shadow <= {num3,num2,num1}.
  - DIG0/DIG1/DIG2 display shadow digit 0/1/2 respectively.
  - Input changes during a frame are ignored until the next DIG0 entry.
- **Decode**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 display a dash (40).
- **err**
  - Set on the edge that snapshots any digit >= 10.
  - Remains set until `rst`; no other event clears it.
- **Logical outputs per state**
  - BLANK: an=000, seg=00.
  - DIGk: an=one-hot bit k, seg=decoded shadow digit k.

## Timing
- `an` and `seg` are registered. They update on the same edge as the state transition, decoded from the next state and next shadow; there are no combinational input-to-output paths.
- The edge entering DIG0 decodes num1 directly, which is the value being captured into the shadow.
- Timing from reset and enable:
  - After `rst` deasserts, the outputs stay BLANK for DIV cycles.
  - The first tick then enters DIG0.
  - One full frame is 3*DIV cycles.
- Reset values, physical:
  - ACTIVE_LOW=1: an=3'b111, seg=7'h7F.
  - ACTIVE_LOW=0: an=3'b000, seg=7'h00.
  - Both polarities: err=0, state BLANK, prescaler 0, shadow 0.
- Clearing `en` takes effect on the next edge: outputs go BLANK and the prescaler clears. Raising `en` restarts from BLANK, and DIG0 is entered DIV cycles later.
- `rst` has priority over `en` and `tick`.

## Configuration
- SCORE_LZB_EN defined (leading-zero blanking):
  - The hundreds digit shows seg=00 when shadow num3==0.
  - The tens digit shows seg=00 when shadow num3==0 and num2==0.
  - The ones digit is never blanked.
  - Illegal codes are never treated as zero.
  - `an` still sequences normally while a digit is blanked.
- SCORE_LZB_EN undefined: all three digits always show their decoded value, including leading zeros.

## Test plan
Benches use DIV=4 and ACTIVE_LOW=0 unless stated.

- **Basic scan:** rst, then num3..num1=3,2,1.
  - BLANK for 4 cycles.
  - Then an=001/seg=06, an=010/seg=5B, an=100/seg=4F, each held exactly 4 cycles.
  - The sequence repeats with period 12.
- **No tearing:** while in DIG1 showing 2, change the inputs to 6,5,4.
  - DIG1 and DIG2 still show 5B and 4F.
  - The next frame shows 66, 6D, 7D.
- **Illegal code:** num2=4'hB.
  - Tens digit shows seg=40.
  - err=1 from the snapshot edge.
  - err stays 1 after num2 returns to 2; only `rst` clears it.
- **Leading zeros:** input 0,0,7.
  - With SCORE_LZB_EN: seg=07, 00, 00.
  - Without SCORE_LZB_EN: 07, 3F, 3F.
  - Input 0,0,0 with SCORE_LZB_EN: ones shows 3F, tens and hundreds show 00.
- **Enable:** drop `en` mid-DIG1.
  - Next edge: an=000, seg=00.
  - Raise `en`: DIG0 appears exactly 4 cycles later, showing the current inputs.
- **Polarity and reset:** ACTIVE_LOW=1, assert `rst` mid-frame.
  - Next edge: an=3'b111, seg=7'h7F, err=0.
  - DIG0 shows physical seg=7'h79 for a digit of 1.

Source files
------------

// File: rtl/score_display_scan.sv
// Three-digit multiplexed seven-segment scanner with per-frame input snapshot and sticky illegal-BCD flag.
// Optional leading-zero blanking is enabled by defining SCORE_LZB_EN.
module score_display_scan #(
    parameter int DIV        = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [3:0] num3,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       err
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [2:0] AN_POL  = {3{ACTIVE_LOW}};
    localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};

    typedef enum logic [1:0] {ST_BLANK, ST_DIG0, ST_DIG1, ST_DIG2} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [CW-1:0] r_cnt;
    logic        w_tick;
    logic        w_load;
    logic [11:0] r_shadow;
    logic [11:0] w_shadow_next;
    logic        w_blank_tens;
    logic        w_blank_hund;
    logic [2:0]  w_an_log;
    logic [6:0]  w_seg_log;
    logic [2:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_err;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        case (d)
            4'd0:    f_decode = 7'h3F;
            4'd1:    f_decode = 7'h06;
            4'd2:    f_decode = 7'h5B;
            4'd3:    f_decode = 7'h4F;
            4'd4:    f_decode = 7'h66;
            4'd5:    f_decode = 7'h6D;
            4'd6:    f_decode = 7'h7D;
            4'd7:    f_decode = 7'h07;
            4'd8:    f_decode = 7'h7F;
            4'd9:    f_decode = 7'h6F;
            default: f_decode = 7'h40;
        endcase
    endfunction

    function automatic logic f_illegal(input logic [3:0] d);
        f_illegal = (d > 4'd9);
    endfunction

    assign w_tick = (r_cnt == CW'(DIV - 1));

    // Prescaler: free-runs 0..DIV-1 while enabled, parked at zero otherwise.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; disabling forces BLANK from any state.
    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = ST_BLANK;
        end else if (w_tick) begin
            case (r_state)
                ST_BLANK: w_state_next = ST_DIG0;
                ST_DIG0:  w_state_next = ST_DIG1;
                ST_DIG1:  w_state_next = ST_DIG2;
                ST_DIG2:  w_state_next = ST_DIG0;
                default:  w_state_next = ST_BLANK;
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    assign w_load = (w_state_next == ST_DIG0) && (r_state != ST_DIG0);

    // Shadow follows the inputs only on frame start so a frame never tears.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_load) begin
            w_shadow_next = {num3, num2, num1};
        end else begin
            w_shadow_next = r_shadow;
        end
    end

`ifdef SCORE_LZB_EN
    assign w_blank_hund = (w_shadow_next[11:8] == 4'd0);
    assign w_blank_tens = w_blank_hund && (w_shadow_next[7:4] == 4'd0);
`else
    assign w_blank_hund = 1'b0;
    assign w_blank_tens = 1'b0;
`endif

    // Output decode from the next state and next shadow, so outputs move with the state.
    always_comb begin
        w_an_log  = 3'b000;
        w_seg_log = 7'h00;
        case (w_state_next)
            ST_DIG0: begin
                w_an_log  = 3'b001;
                w_seg_log = f_decode(w_shadow_next[3:0]);
            end
            ST_DIG1: begin
                w_an_log  = 3'b010;
                w_seg_log = w_blank_tens ? 7'h00 : f_decode(w_shadow_next[7:4]);
            end
            ST_DIG2: begin
                w_an_log  = 3'b100;
                w_seg_log = w_blank_hund ? 7'h00 : f_decode(w_shadow_next[11:8]);
            end
            default: begin
                w_an_log  = 3'b000;
                w_seg_log = 7'h00;
            end
        endcase
    end

    // Shadow, sticky error and physical output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= 12'h000;
            r_err    <= 1'b0;
            r_an     <= AN_POL;
            r_seg    <= SEG_POL;
        end else begin
            r_shadow <= w_shadow_next;
            if (w_load && (f_illegal(num1) || f_illegal(num2) || f_illegal(num3))) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
            r_an  <= w_an_log ^ AN_POL;
            r_seg <= w_seg_log ^ SEG_POL;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign err = r_err;

endmodule

// File: tb/tb_score_display_scan.sv
// Scoreboard bench for score_display_scan: both polarities run side by side on shared stimulus.
module tb_score_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] num1, num2, num3;
    logic [6:0] seg_hi, seg_lo;
    logic [2:0] an_hi, an_lo;
    logic       err_hi, err_lo;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [2:0] an;
        logic [6:0] seg;
        logic       err;
    } exp_t;

    exp_t sb_q[$];

`ifdef SCORE_LZB_EN
    localparam logic [6:0] ZERO_LEAD = 7'h00;
`else
    localparam logic [6:0] ZERO_LEAD = 7'h3F;
`endif

    score_display_scan #(.DIV(4), .ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk(clk), .rst(rst), .en(en), .num1(num1), .num2(num2), .num3(num3),
        .seg(seg_hi), .an(an_hi), .err(err_hi)
    );

    score_display_scan #(.DIV(4), .ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk(clk), .rst(rst), .en(en), .num1(num1), .num2(num2), .num3(num3),
        .seg(seg_lo), .an(an_lo), .err(err_lo)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [2:0] a, input logic [6:0] s, input logic e, input int n);
        exp_t x;
        x.an  = a;
        x.seg = s;
        x.err = e;
        for (int i = 0; i < n; i++) sb_q.push_back(x);
    endtask

    task automatic cmp(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock per queued entry; sample 1 time unit after the edge.
    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            cmp("an_hi",  {4'b0000, an_hi},  {4'b0000, e.an});
            cmp("seg_hi", seg_hi,            e.seg);
            cmp("err_hi", {6'b0, err_hi},    {6'b0, e.err});
            cmp("an_lo",  {4'b0000, an_lo},  {4'b0000, ~e.an});
            cmp("seg_lo", seg_lo,            ~e.seg);
            cmp("err_lo", {6'b0, err_lo},    {6'b0, e.err});
        end
    endtask

    task automatic set_num(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        num3 = h;
        num2 = t;
        num1 = o;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        set_num(4'd0, 4'd0, 4'd0);

        // Reset state
        push(3'b000, 7'h00, 1'b0, 2);
        drain();

        // Basic scan: 3,2,1
        set_num(4'd3, 4'd2, 4'd1);
        rst = 1'b0;
        push(3'b000, 7'h00, 1'b0, 3);
        for (int f = 0; f < 2; f++) begin
            push(3'b001, 7'h06, 1'b0, 4);
            push(3'b010, 7'h5B, 1'b0, 4);
            push(3'b100, 7'h4F, 1'b0, 4);
        end
        push(3'b001, 7'h06, 1'b0, 4);
        push(3'b010, 7'h5B, 1'b0, 2);
        drain();

        // No tearing: change inputs mid-DIG1
        set_num(4'd6, 4'd5, 4'd4);
        push(3'b010, 7'h5B, 1'b0, 2);
        push(3'b100, 7'h4F, 1'b0, 4);
        push(3'b001, 7'h66, 1'b0, 4);
        push(3'b010, 7'h6D, 1'b0, 4);
        push(3'b100, 7'h7D, 1'b0, 2);
        drain();

        // Illegal tens code, then restored
        set_num(4'd6, 4'hB, 4'd4);
        push(3'b100, 7'h7D, 1'b0, 2);
        push(3'b001, 7'h66, 1'b1, 4);
        push(3'b010, 7'h40, 1'b1, 2);
        drain();
        set_num(4'd6, 4'd2, 4'd4);
        push(3'b010, 7'h40, 1'b1, 2);
        push(3'b100, 7'h7D, 1'b1, 2);
        drain();
        push(3'b100, 7'h7D, 1'b1, 2);
        push(3'b001, 7'h66, 1'b1, 4);
        push(3'b010, 7'h5B, 1'b1, 4);
        push(3'b100, 7'h7D, 1'b1, 2);
        drain();

        // Leading zeros: 0,0,7
        set_num(4'd0, 4'd0, 4'd7);
        push(3'b100, 7'h7D, 1'b1, 2);
        push(3'b001, 7'h07, 1'b1, 4);
        push(3'b010, ZERO_LEAD, 1'b1, 4);
        push(3'b100, ZERO_LEAD, 1'b1, 2);
        drain();

        // Leading zeros: 0,0,0 (ones never blanked)
        set_num(4'd0, 4'd0, 4'd0);
        push(3'b100, ZERO_LEAD, 1'b1, 2);
        push(3'b001, 7'h3F, 1'b1, 4);
        push(3'b010, ZERO_LEAD, 1'b1, 4);
        push(3'b100, ZERO_LEAD, 1'b1, 4);
        push(3'b001, 7'h3F, 1'b1, 4);
        push(3'b010, ZERO_LEAD, 1'b1, 2);
        drain();

        // Enable drop mid-DIG1, then restart with new inputs
        en = 1'b0;
        set_num(4'd5, 4'd8, 4'd9);
        push(3'b000, 7'h00, 1'b1, 2);
        drain();
        en = 1'b1;
        push(3'b000, 7'h00, 1'b1, 3);
        push(3'b001, 7'h6F, 1'b1, 4);
        push(3'b010, 7'h7F, 1'b1, 4);
        push(3'b100, 7'h6D, 1'b1, 4);
        push(3'b001, 7'h6F, 1'b1, 4);
        push(3'b010, 7'h7F, 1'b1, 1);
        drain();

        // Reset mid-frame clears err; digit 1 on the active-low part reads 79
        rst = 1'b1;
        push(3'b000, 7'h00, 1'b0, 1);
        drain();
        rst = 1'b0;
        set_num(4'd3, 4'd2, 4'd1);
        push(3'b000, 7'h00, 1'b0, 3);
        push(3'b001, 7'h06, 1'b0, 4);
        push(3'b010, 7'h5B, 1'b0, 2);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
